// File: rtl/fanout_pkg.sv
// Shared sizing and token type for the eager fanout fork.
package fanout_pkg;

   localparam int FANOUT_NUM_OUT = 7;
   localparam int FANOUT_DATA_W  = 17;
   localparam int FANOUT_STALL_W = 16;

   typedef logic [FANOUT_DATA_W-1:0] fanout_token_t;

endpackage

// File: rtl/fanout_taken_flag.sv
// Per-branch "taken" bit: set when the branch accepts the buffered token.
// Latency: updates on the next edge. Clear wins over set so a retiring token never leaves a stale flag.
module fanout_taken_flag (
   input  logic CLK,
   input  logic ASYNCRESET,
   input  logic set,
   input  logic clr,
   output logic taken
);

   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         taken <= 1'b0;
      end else if (clr) begin
         taken <= 1'b0;
      end else if (set) begin
         taken <= 1'b1;
      end
   end

endmodule

// File: rtl/fanout_eager_fork.sv
// Eager fork: one buffered token broadcast to NUM_OUT branches, each taking it independently.
// Latency 1 cycle in->out; in_ready is combinational from out_ready (retire + reload in one edge).
// Optional stall counter under `FANOUT_STALL_CNT_EN`.
module fanout_eager_fork
   import fanout_pkg::*;
#(
   parameter int NUM_OUT = FANOUT_NUM_OUT,
   parameter int DATA_W  = FANOUT_DATA_W
) (
   input  logic                      CLK,
   input  logic                      ASYNCRESET,
   input  logic                      in_valid,
   input  logic [DATA_W-1:0]         in_data,
   output logic                      in_ready,
   input  logic [NUM_OUT-1:0]        cfg_en,
   input  logic [NUM_OUT-1:0]        cfg_sel,
   output logic [NUM_OUT-1:0]        out_valid,
   output logic [NUM_OUT*DATA_W-1:0] out_data,
   input  logic [NUM_OUT-1:0]        out_ready
`ifdef FANOUT_STALL_CNT_EN
   ,
   output logic [FANOUT_STALL_W-1:0] stall_cnt
`endif
);

   logic               buf_valid;
   logic [DATA_W-1:0]  buf_data;
   logic [NUM_OUT-1:0] active;
   logic [NUM_OUT-1:0] taken;
   logic [NUM_OUT-1:0] branch_set;
   logic               fork_done;
   logic               load;
   logic               clr;

   assign active     = cfg_en & cfg_sel;
   assign out_valid  = {NUM_OUT{buf_valid}} & active & ~taken;
   // A branch stops gating retirement once it is inactive, has taken the token, or takes it now.
   assign fork_done  = buf_valid & (&(~active | taken | out_ready));
   assign in_ready   = ~buf_valid | fork_done;
   assign load       = in_valid & in_ready;
   assign clr        = fork_done | load;
   assign branch_set = out_valid & out_ready;
   assign out_data   = {NUM_OUT{buf_data}};

   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         buf_valid <= 1'b0;
         buf_data  <= '0;
      end else if (load) begin
         buf_valid <= 1'b1;
         buf_data  <= in_data;
      end else if (fork_done) begin
         buf_valid <= 1'b0;
      end
   end

   for (genvar i = 0; i < NUM_OUT; i++) begin : g_taken
      fanout_taken_flag u_taken (
         .CLK        (CLK),
         .ASYNCRESET (ASYNCRESET),
         .set        (branch_set[i]),
         .clr        (clr),
         .taken      (taken[i])
      );
   end

`ifdef FANOUT_STALL_CNT_EN
   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         stall_cnt <= '0;
      end else if (buf_valid && !fork_done && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fanout_eager_fork.sv
// Bench for fanout_eager_fork: directed literal cases plus randomized traffic against a token-level model.
module tb_fanout_eager_fork;
   import fanout_pkg::*;

   localparam int N = FANOUT_NUM_OUT;
   localparam int W = FANOUT_DATA_W;

   logic             CLK = 1'b0;
   logic             ASYNCRESET = 1'b1;
   logic             in_valid = 1'b0;
   logic [W-1:0]     in_data = '0;
   logic             in_ready;
   logic [N-1:0]     cfg_en = '0;
   logic [N-1:0]     cfg_sel = '0;
   logic [N-1:0]     out_valid;
   logic [N*W-1:0]   out_data;
   logic [N-1:0]     out_ready = '0;
`ifdef FANOUT_STALL_CNT_EN
   logic [FANOUT_STALL_W-1:0] stall_cnt;
`endif

   int checks = 0;
   int failures = 0;

   fanout_eager_fork dut (
      .CLK        (CLK),
      .ASYNCRESET (ASYNCRESET),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .cfg_en     (cfg_en),
      .cfg_sel    (cfg_sel),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready)
`ifdef FANOUT_STALL_CNT_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model: one pending token + who has it ----------------
   bit           m_has;
   logic [W-1:0] m_tok;
   bit           m_got [N];
   int           m_stall;
   logic [W-1:0] sb [N][$];

   always @(negedge CLK) begin
      logic [N-1:0] act, exp_ov;
      bit           exp_done, exp_ir;
      logic [W-1:0] slice;
      if (ASYNCRESET) begin
         m_has = 0; m_tok = '0; m_stall = 0;
         for (int i = 0; i < N; i++) begin m_got[i] = 0; sb[i].delete(); end
         chk("rst_out_valid", out_valid, '0);
         chk("rst_in_ready", in_ready, 1'b1);
      end else begin
         act = cfg_en & cfg_sel;
         exp_done = m_has;
         for (int i = 0; i < N; i++) begin
            exp_ov[i] = m_has && act[i] && !m_got[i];
            if (act[i] && !m_got[i] && !out_ready[i]) exp_done = 0;
         end
         exp_ir = !m_has || exp_done;
         chk("mdl_out_valid", out_valid, exp_ov);
         chk("mdl_in_ready", in_ready, exp_ir);
         chk("mdl_out_data", out_data, {N{m_tok}});
`ifdef FANOUT_STALL_CNT_EN
         chk("mdl_stall_cnt", stall_cnt, m_stall);
         if (m_has && !exp_done && m_stall < 65535) m_stall++;
`endif
         // transaction scoreboard: each handshake must deliver the next token owed to that branch
         for (int i = 0; i < N; i++) begin
            if (out_valid[i] && out_ready[i]) begin
               slice = out_data[i*W +: W];
               if (sb[i].size() == 0) chk("sb_unexpected_delivery", 1, 0);
               else chk("sb_delivery", slice, sb[i].pop_front());
            end
         end
         if (in_valid && exp_ir) begin
            m_has = 1; m_tok = in_data;
            for (int i = 0; i < N; i++) begin
               m_got[i] = 0;
               if (act[i]) sb[i].push_back(in_data);
            end
         end else if (exp_done) begin
            m_has = 0;
            for (int i = 0; i < N; i++) m_got[i] = 0;
         end else begin
            for (int i = 0; i < N; i++) if (exp_ov[i] && out_ready[i]) m_got[i] = 1;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge CLK); #1;
   endtask

   task automatic drain();
      in_valid = 0; out_ready = '1;
      repeat (3) step();
   endtask

   task automatic pulse_reset();
      step(); ASYNCRESET = 1; step(); step(); ASYNCRESET = 0;
   endtask

   initial begin
      logic [W-1:0] d0;
      repeat (2) step();
      @(negedge CLK);
      chk("reset_out_valid", out_valid, '0);
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_out_data", out_data, '0);
      step(); ASYNCRESET = 0;

      // full broadcast, 1 token/cycle
      cfg_en = 7'h7F; cfg_sel = 7'h7F; out_ready = 7'h7F;
      step(); in_valid = 1; in_data = 17'h00001;
      for (int k = 1; k <= 4; k++) begin
         step();
         if (k < 4) in_data = W'(k + 1); else in_valid = 0;
         @(negedge CLK);
         d0 = out_data[W-1:0];
         chk("bcast_out_valid", out_valid, 7'h7F);
         chk("bcast_data", d0, k);
         chk("bcast_in_ready", in_ready, 1'b1);
      end
      drain();

      // staggered accept on branches 0 and 2
      cfg_sel = 7'h05; out_ready = '0; in_valid = 1; in_data = 17'h1ABCD;
      step(); in_valid = 0; out_ready = 7'h01;
      @(negedge CLK);
      chk("stag_c1_valid", out_valid, 7'h05); chk("stag_c1_ready", in_ready, 1'b0);
      step(); out_ready = 7'h00;
      @(negedge CLK);
      chk("stag_c2_valid", out_valid, 7'h04); chk("stag_c2_ready", in_ready, 1'b0);
      step(); out_ready = 7'h04;
      @(negedge CLK);
      chk("stag_c3_valid", out_valid, 7'h04); chk("stag_c3_ready", in_ready, 1'b1);
      d0 = out_data[2*W +: W];
      chk("stag_c3_data", d0, 17'h1ABCD);
      step(); out_ready = 7'h00;
      @(negedge CLK);
      chk("stag_c4_valid", out_valid, 7'h00); chk("stag_c4_ready", in_ready, 1'b1);
      drain();

      // masked branch: only branch 1 routed
      cfg_sel = 7'h02; out_ready = 7'h00; in_valid = 1; in_data = 17'h0BEEF;
      step(); in_valid = 0;
      @(negedge CLK);
      chk("mask_stuck_valid", out_valid, 7'h02); chk("mask_stuck_ready", in_ready, 1'b0);
      step(); out_ready = 7'h02;
      @(negedge CLK);
      chk("mask_go_valid", out_valid, 7'h02); chk("mask_go_ready", in_ready, 1'b1);
      drain();

      // no active branch: tokens drop after one cycle, no backpressure
      cfg_sel = 7'h00; out_ready = 7'h00; in_valid = 1;
      for (int k = 0; k < 3; k++) begin
         in_data = W'(17'h100 + k);
         step();
         @(negedge CLK);
         chk("noact_valid", out_valid, 7'h00); chk("noact_ready", in_ready, 1'b1);
      end
      drain();

      // async reset with a pending token
      cfg_sel = 7'h01; out_ready = 7'h00; in_valid = 1; in_data = 17'h15555;
      step(); in_valid = 0;
      @(posedge CLK); #3 ASYNCRESET = 1; #1;
      chk("arst_out_valid", out_valid, 7'h00);
      chk("arst_in_ready", in_ready, 1'b1);
      step(); ASYNCRESET = 0; out_ready = 7'h7F;
      repeat (2) begin
         @(negedge CLK);
         chk("arst_never_delivered", out_valid, 7'h00);
         step();
      end

      // randomized traffic, config changed only while idle
      for (int p = 0; p < 8; p++) begin
         cfg_en = N'($urandom); cfg_sel = N'($urandom);
         if (p == 0) cfg_sel = '0;
         for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = W'($urandom);
            for (int i = 0; i < N; i++) out_ready[i] = ($urandom_range(0, 9) < 6);
            step();
         end
         drain();
         for (int i = 0; i < N; i++) chk("sb_drained", sb[i].size(), 0);
      end

`ifdef FANOUT_STALL_CNT_EN
      pulse_reset();
      cfg_en = 7'h7F; cfg_sel = 7'h01; out_ready = 7'h00; in_valid = 1; in_data = 17'h00077;
      step(); in_valid = 0;
      repeat (20) @(posedge CLK);
      @(negedge CLK);
      chk("stall_20", stall_cnt, 16'd20);
      repeat (70000) @(posedge CLK);
      @(negedge CLK);
      chk("stall_sat", stall_cnt, 16'hFFFF);
      #1;
      drain();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
